muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the integer datapath. Consumes register-file read
//  values (rs1/rs2 data) plus destination index; produces a writeback (rd, data, write-enable)
//  that drives the register-file write port. While busy the core stalls on ready=0.
// PARAMETERS
//  XLEN  32  operand/result width; must equal the width of base::cpu_word
// PORTS
//  clk       in   1     rising-edge clock
//  reset_n   in   1     asynchronous, active-low reset
//  start     in   1     request; accepted on an edge where start && ready && !kill
//  op        in   3     base::muldiv_op: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  a         in   XLEN  rs1 data
//  b         in   XLEN  rs2 data
//  rd_in     in   5     base::reg_select destination
//  kill      in   1     abort in-flight op (pipeline flush)
//  ready     out  1     1 = idle, can accept start
//  wb_valid  out  1     one-cycle pulse: result valid; drives register-file rdWE
//  wb_rd     out  5     destination of the result
//  wb_data   out  XLEN  result
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, ready=1, wb_valid=0, wb_rd=0, wb_data=0, counter=0.
//  - FSM IDLE -> RUN (accept, iterative op) -> DONE -> IDLE; IDLE -> DONE for 1-cycle cases.
//    RUN: one shift-add / restoring-subtract step per cycle, counter XLEN-1 down to 0;
//    RUN -> DONE when counter==0. DONE: wb_valid=1 for exactly one cycle, then IDLE.
//  - ready=1 only in IDLE. start while !ready is ignored (no queueing); upstream must hold.
//  - Latency (accept edge = k): iterative op -> wb_valid high in cycle k+XLEN+1;
//    1-cycle cases -> wb_valid high in cycle k+1. Back-to-back accept allowed in the cycle
//    after DONE (ready rises as wb_valid falls).
//  - Operands, op, rd_in latched at accept; a/b may change afterwards.
//  - Signed ops: operate on magnitudes, negate result by sign rules. MULH: signed x signed,
//    MULHSU: signed a x unsigned b, MULHU: unsigned; MUL returns low XLEN bits, MULH* high XLEN
//    of the 2*XLEN product. REM takes the sign of the dividend.
//  - Divide by zero (1-cycle case): DIV/DIVU -> all ones; REM/REMU -> a. No trap.
//  - Signed overflow a=-2^(XLEN-1), b=-1 (1-cycle case): DIV -> -2^(XLEN-1); REM -> 0.
//  - rd_in==0: op still runs and wb_valid pulses with wb_rd=0; register file discards it.
//  - kill: any state -> IDLE on next edge, no wb_valid for the killed op; kill in DONE
//    suppresses that pulse. start && kill in the same cycle: kill wins, nothing accepted.
//  - wb_rd/wb_data hold their last values outside the wb_valid pulse.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU are 1-cycle cases using a combinational
//    2*XLEN-bit multiplier; wb_valid in cycle k+1. Divides remain iterative.
//  Undefined: all multiplies use the iterative shift-add path, latency XLEN+1. Results
//    identical in both builds; only latency differs.
// STRUCTURE
//  - Package base gains: typedef enum logic [2:0] muldiv_op; typedef enum muldiv_state
//    {MD_IDLE, MD_RUN, MD_DONE}; uses existing cpu_word, reg_select.
//  - Sub-module muldiv_sign_fix: combinational operand-magnitude and result-negation logic
//    shared by both paths. Iterative datapath and FSM stay in muldiv_unit.
// TESTING
//  1. DIV a=-7 b=2 accepted at k -> wb_valid only in cycle k+33, wb_data=-3, REM -> -1.
//  2. DIVU a=100 b=0 -> wb_data=0xFFFFFFFF in cycle k+1; REMU a=100 b=0 -> 100.
//  3. DIV a=0x80000000 b=-1 -> 0x80000000; REM same operands -> 0; both at k+1.
//  4. MULH a=-1 b=-1 -> 0; MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE; MUL 7x-3 -> -21;
//     latency k+33 without MULDIV_FAST_MUL_EN, k+1 with it.
//  5. DIV issued, kill at k+10 -> no wb_valid, ready=1 at k+11; start+kill together -> ignored.
//  6. reset_n low mid-RUN -> ready=1, wb_valid=0 immediately; second start while busy ignored.

Source files
------------

// File: rtl/base_pkg.sv
// rtl/base_pkg.sv - shared CPU types plus muldiv op/state enums and divide special-case helpers.
package base;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] cpu_word;
  typedef logic [4:0]      reg_select;

  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} muldiv_state;

  function automatic logic is_div(muldiv_op op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  // Divide by zero and signed overflow finish in one cycle with fixed results.
  function automatic logic div_special(muldiv_op op, cpu_word a, cpu_word b);
    logic ovf;
    ovf = (op inside {DIV, REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    return is_div(op) && ((b == '0) || ovf);
  endfunction

  function automatic cpu_word div_special_result(muldiv_op op, cpu_word a, cpu_word b);
    if (b == '0) return (op inside {DIV, DIVU}) ? '1 : a;
    return (op == DIV) ? a : '0;
  endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - operand magnitudes and sign-corrected result selection for muldiv_unit.
module muldiv_sign_fix (
  input  logic [2:0]            op,
  input  logic [base::XLEN-1:0] a,
  input  logic [base::XLEN-1:0] b,
  input  logic [2*base::XLEN-1:0] mag_prod,
  input  logic [base::XLEN-1:0] mag_quot,
  input  logic [base::XLEN-1:0] mag_rem,
  output logic [base::XLEN-1:0] abs_a,
  output logic [base::XLEN-1:0] abs_b,
  output logic [base::XLEN-1:0] result
);
  import base::*;

  muldiv_op op_e;
  logic     neg_a;
  logic     neg_b;
  logic [2*XLEN-1:0] prod_s;
  cpu_word  quot_s;
  cpu_word  rem_s;

  assign op_e  = muldiv_op'(op);
  assign neg_a = (op_e inside {MULH, MULHSU, DIV, REM}) && a[XLEN-1];
  assign neg_b = (op_e inside {MULH, DIV, REM}) && b[XLEN-1];
  assign abs_a = neg_a ? -a : a;
  assign abs_b = neg_b ? -b : b;

  // Remainder follows the dividend's sign; product and quotient follow the xor.
  assign prod_s = (neg_a ^ neg_b) ? -mag_prod : mag_prod;
  assign quot_s = (neg_a ^ neg_b) ? -mag_quot : mag_quot;
  assign rem_s  = neg_a ? -mag_rem : mag_rem;

  always_comb begin
    result = '0;
    case (op_e)
      MUL:                  result = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU:  result = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:            result = quot_s;
      default:              result = rem_s;
    endcase
  end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file writeback.
// MULDIV_FAST_MUL_EN turns multiplies into single-cycle operations.
module muldiv_unit #(
  parameter int XLEN = base::XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            ready,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);
  import base::*;

  muldiv_state state, state_nxt;
  muldiv_op    op_in, op_r;
  logic [4:0]  cnt;
  cpu_word     a_r, b_r, data_q;
  reg_select   rd_r, rd_q;
  logic [2*XLEN-1:0] acc, acc_step, mul_step, mag_prod;
  logic [XLEN:0]     rem_t;
  logic [XLEN-1:0]   rem_diff;
  logic        rem_ge;
  cpu_word     abs_a, abs_b, fix_result, result;
  logic        accept, one_cycle_in;

  assign op_in  = muldiv_op'(op);
  assign ready  = (state == MD_IDLE);
  assign accept = start && ready && !kill;

`ifdef MULDIV_FAST_MUL_EN
  assign one_cycle_in = !is_div(op_in) || div_special(op_in, a, b);
  assign mag_prod     = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`else
  assign one_cycle_in = div_special(op_in, a, b);
  assign mag_prod     = acc;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = one_cycle_in ? MD_DONE : MD_RUN;
      MD_RUN:  if (cnt == '0) state_nxt = MD_DONE;
      default: state_nxt = MD_IDLE;
    endcase
    if (kill) state_nxt = MD_IDLE;
  end

  // Both paths walk operand bits MSB-first, indexed by the down counter.
  assign mul_step = {acc[2*XLEN-2:0], 1'b0} + (abs_b[cnt] ? {{XLEN{1'b0}}, abs_a} : '0);
  assign rem_t    = {acc[2*XLEN-1:XLEN], abs_a[cnt]};
  assign rem_ge   = rem_t >= {1'b0, abs_b};
  assign rem_diff = rem_t[XLEN-1:0] - abs_b;
  assign acc_step = !is_div(op_r) ? mul_step :
                    rem_ge ? {rem_diff, acc[XLEN-2:0], 1'b1}
                           : {rem_t[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  muldiv_sign_fix u_sign_fix (
    .op       (op_r),
    .a        (a_r),
    .b        (b_r),
    .mag_prod (mag_prod),
    .mag_quot (acc[XLEN-1:0]),
    .mag_rem  (acc[2*XLEN-1:XLEN]),
    .abs_a    (abs_a),
    .abs_b    (abs_b),
    .result   (fix_result)
  );

  assign result   = div_special(op_r, a_r, b_r) ? div_special_result(op_r, a_r, b_r) : fix_result;
  assign wb_valid = (state == MD_DONE) && !kill;
  assign wb_data  = wb_valid ? result : data_q;
  assign wb_rd    = wb_valid ? rd_r : rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_r   <= MUL;
      a_r    <= '0;
      b_r    <= '0;
      rd_r   <= '0;
      acc    <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r <= op_in;
        a_r  <= a;
        b_r  <= b;
        rd_r <= rd_in;
        acc  <= '0;
        cnt  <= 5'(XLEN-1);
      end else if (state == MD_RUN && !kill) begin
        acc <= acc_step;
        if (cnt != '0) cnt <= cnt - 5'd1;
      end
      if (wb_valid) begin
        data_q <= result;
        rd_q   <= rd_r;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        ready, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad = 0;
  logic        done = 1'b0;
  logic        lit_on = 1'b0;
  logic [31:0] lit_data = '0;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .rd_in(rd_in), .kill(kill), .ready(ready), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    ovf = (ma == 32'h8000_0000) && (mb == 32'hFFFF_FFFF);
    p   = '0;
    case (mop)
      OP_MUL:    begin p = {32'b0, ma} * {32'b0, mb}; return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * longint'({32'b0, mb})); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, ma} * {32'b0, mb}; return p[63:32]; end
      OP_DIV:    return (mb == 0) ? 32'hFFFF_FFFF : ovf ? ma : 32'(sa / sb);
      OP_DIVU:   return (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
      OP_REM:    return (mb == 0) ? ma : ovf ? 32'd0 : 32'(sa % sb);
      default:   return (mb == 0) ? ma : ma % mb;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    logic div_op;
    div_op = mop[2];
    if (div_op && (mb == 0)) return 1;
    if ((mop == OP_DIV || mop == OP_REM) && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!div_op) return 1;
`endif
    return 33;
  endfunction

  // Reference scoreboard: one outstanding op, its due cycle and result.
  int          cyc = 0;
  int          due = 0;
  logic        pend = 1'b0;
  logic        acc_now;
  logic [31:0] exp_data = '0, last_data = '0;
  logic [4:0]  exp_rd = '0, last_rd = '0;

  always @(posedge clk) begin
    acc_now = 1'b0;
    if (!reset_n) begin
      pend = 1'b0; last_data = '0; last_rd = '0;
    end else begin
      acc_now = start && !kill && !pend;
      if (pend && cyc == due) begin
        if (!kill) begin last_data = exp_data; last_rd = exp_rd; end
        pend = 1'b0;
      end else if (kill) pend = 1'b0;
    end
    cyc = cyc + 1;
    if (acc_now) begin
      pend     = 1'b1;
      due      = cyc + latency(op, a, b) - 1;
      exp_data = model(op, a, b);
      exp_rd   = rd_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  logic ev;
  always @(negedge clk) begin
    if (!done) begin
      if (!reset_n) begin
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_valid", {31'b0, wb_valid}, 32'd0);
        chk("reset_data", wb_data, 32'd0);
        chk("reset_rd", {27'b0, wb_rd}, 32'd0);
      end else begin
        ev = pend && cyc == due && !kill;
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
        chk("ready", {31'b0, ready}, {31'b0, !pend});
        chk("wb_data", wb_data, ev ? exp_data : last_data);
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, ev ? exp_rd : last_rd});
        if (ev && lit_on) chk("literal", wb_data, lit_data);
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    op = o; a = x; b = y; rd_in = r;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
    @(posedge clk); #1;
    drive(o, x, y, r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] want);
    lit_data = want; lit_on = 1'b1;
    issue(o, x, y, r);
    repeat (36) @(posedge clk);
    lit_on = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,        5'd1,  32'hFFFF_FFFD);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF);
    run_op(OP_DIVU,   32'd100,       32'd0,        5'd3,  32'hFFFF_FFFF);
    run_op(OP_REMU,   32'd100,       32'd0,        5'd4,  32'd100);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE);
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF);
    run_op(OP_MUL,    32'h1234_5678, 32'h10,       5'd11, 32'h2345_6780);
    run_op(OP_DIVU,   32'd100,       32'd7,        5'd0,  32'd14);
    run_op(OP_REMU,   32'd100,       32'd7,        5'd12, 32'd2);
    run_op(OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD);
    run_op(OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1);

    // kill mid-divide
    issue(OP_DIV, 32'd1000, 32'd3, 5'd15);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    repeat (3) @(posedge clk);

    // kill during the writeback cycle of a one-cycle op
    issue(OP_DIVU, 32'd5, 32'd0, 5'd16);
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    repeat (3) @(posedge clk);

    // start and kill together
    @(posedge clk); #1;
    drive(OP_MUL, 32'd3, 32'd4, 5'd17); start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);

    // second start while busy is ignored
    issue(OP_DIVU, 32'd999, 32'd10, 5'd18);
    repeat (4) @(posedge clk);
    #1 drive(OP_MUL, 32'd5, 32'd5, 5'd19); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (36) @(posedge clk);

    // back-to-back one-cycle ops with start held
    @(posedge clk); #1;
    drive(OP_REMU, 32'd77, 32'd0, 5'd20); start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);

    // asynchronous reset mid-run, then recovery
    issue(OP_DIV, 32'd12345, 32'd67, 5'd21);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_op(OP_DIVU, 32'd12345, 32'd67, 5'd22, 32'd184);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
